// File: rtl/cpu_control_unit.sv
// Hardwired control sequencer for the mini-CPU datapath.
// A registered state walks fetch (T0-T2), decode (T3), and execute (T4-T5).
// Every strobe is a combinational decode of the state and IR, so pulling
// Reset_n low clears all outputs at once, without waiting for a clock edge.
module cpu_control_unit #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [31:0]     IR,
    input  logic            Mem_ready,
    input  logic            Stop,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            MARin,
    output logic            Zin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            IncPC,
    output logic            Read,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            Cout,
    output logic [ALUW-1:0] ALU_op,
    output logic            Run,
    output logic            Illegal
);

    typedef enum logic [2:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t          state_reg;
    logic [OPW-1:0]  opcode;
    logic            is_rtype;
    logic            is_imm;
    logic            is_alu;
    logic            is_nop;
    logic            is_halt;
    logic [ALUW-1:0] alu_code;
    logic            unused_ir_bits;

    assign opcode         = IR[31 -: OPW];
    assign unused_ir_bits = ^IR[31-OPW:0];

    // Opcode classification and ALU function select; both ALU classes share one table.
    always_comb begin
        is_rtype = 1'b0;
        is_imm   = 1'b0;
        alu_code = '0;
        case (opcode)
            OP_ADD:  begin is_rtype = 1'b1; alu_code = ALUW'(1); end
            OP_SUB:  begin is_rtype = 1'b1; alu_code = ALUW'(2); end
            OP_AND:  begin is_rtype = 1'b1; alu_code = ALUW'(3); end
            OP_OR:   begin is_rtype = 1'b1; alu_code = ALUW'(4); end
            OP_SHR:  begin is_rtype = 1'b1; alu_code = ALUW'(5); end
            OP_SHL:  begin is_rtype = 1'b1; alu_code = ALUW'(6); end
            OP_ADDI: begin is_imm   = 1'b1; alu_code = ALUW'(1); end
            OP_ANDI: begin is_imm   = 1'b1; alu_code = ALUW'(3); end
            OP_ORI:  begin is_imm   = 1'b1; alu_code = ALUW'(4); end
            default: ;
        endcase
    end

    assign is_alu  = is_rtype | is_imm;
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);

    // Sequencer: every entry into T0 is an instruction boundary, where a live Stop diverts to HALT.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_RST;
        end else begin
            case (state_reg)
                ST_RST:  state_reg <= Stop ? ST_HALT : ST_T0;
                ST_T0:   state_reg <= ST_T1;
                ST_T1:   if (Mem_ready) state_reg <= ST_T2;
                ST_T2:   state_reg <= ST_T3;
                ST_T3: begin
                    if (is_alu)       state_reg <= ST_T4;
                    else if (is_halt) state_reg <= ST_HALT;
                    else              state_reg <= Stop ? ST_HALT : ST_T0;
                end
                ST_T4:   state_reg <= ST_T5;
                ST_T5:   state_reg <= Stop ? ST_HALT : ST_T0;
                ST_HALT: state_reg <= ST_HALT;
                default: state_reg <= ST_RST;
            endcase
        end
    end

    // Strobe decode: each state drives at most one bus source; ALU_op is nonzero only in T4.
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        Cout    = 1'b0;
        ALU_op  = '0;
        Illegal = 1'b0;
        Run     = (state_reg != ST_RST) && (state_reg != ST_HALT);
        case (state_reg)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                if (is_alu) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (!is_nop && !is_halt) begin
                    Illegal = 1'b1;
                end
            end
            ST_T4: begin
                if (is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = alu_code;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1; ALU_op = alu_code;
                end
            end
            ST_T5: begin
                Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Hardwired control sequencer for the mini-CPU datapath.
- Generates, cycle by cycle, the datapath strobes that the datapath bench currently drives by hand: PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, plus register-select and ALU-op controls.
- Fetch T0–T2, then decode and execute of R-type/immediate ALU, nop and halt.
- Sits beside the datapath: consumes IR and a memory-ready handshake, drives all control inputs.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ALUW, 4, width of ALU_op encoding.

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- IR  in  32  instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
- Mem_ready  in  1  memory read data valid this cycle
- Stop  in  1  request halt at next instruction boundary
- PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath strobes
- Gra, Grb, Grc  out  1 each  select Ra/Rb/Rc field for the register select/encode logic
- Rin, Rout  out  1 each  write/drive the selected register
- Cout  out  1  drive sign-extended IR[18:0] onto bus
- ALU_op  out  4  0=pass, 1=add, 2=sub, 3=and, 4=or, 5=shr, 6=shl
- Run  out  1  high while executing
- Illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- States: RST, T0, T1, T2, T3, T4, T5, HALT. State is registered; outputs are a combinational decode of state and IR.
- Reset_n low: state = RST immediately; all outputs 0; ALU_op = 0. The first rising edge after release moves RST -> T0.
- Run = 0 in RST and HALT, 1 otherwise.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
  - Stays in T1 while Mem_ready = 0; advances to T2 on the edge where Mem_ready = 1.
  - Repeated PCin while waiting is harmless: Z still holds PC+1.
- T2: MDRout, IRin. IR is valid from T3 onward, so decode happens in T3.
- T3, by opcode:
  - R-type (00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl) and immediate (01100 addi, 01101 andi, 01110 ori): Grb, Rout, Yin; next T4.
  - 11010 nop: no strobes; next T0.
  - 11011 halt: no strobes; next HALT.
  - Any other opcode: no strobes except Illegal = 1; next T0.
- T4:
  - R-type: Grc, Rout, Zin, ALU_op per opcode.
  - Immediate: Cout, Zin, ALU_op add/and/or.
  - Next T5.
- T5: Zlowout, Gra, Rin; next T0.
- Instruction boundary: any transition into T0. If Stop = 1 at that edge, go to HALT instead of T0.
  - A mid-instruction Stop is held off until the boundary; Stop is not latched, so it must still be high at that edge.
- HALT: all strobes 0, Run = 0. Exit only via Reset_n.
- At most one bus driver is active in any state (PCout, Zlowout, MDRout, Rout, Cout are mutually exclusive).
- ALU_op = 0 in every state except T4.
- Latency, counting every state from T0 through the last execute state:
  - ALU instruction: 6 cycles plus memory wait cycles.
  - nop or illegal opcode: 4 cycles plus memory wait cycles.
- Reset asserted in any state, including T1 mid-wait: immediate return to RST with all outputs 0.

Test Plan:
- Reset release, Mem_ready tied 1, IR = 0x28918000 (and R1,R2,R3): states T0..T5 then T0.
  - T3: Grb, Rout, Yin. T4: Grc, Rout, Zin, ALU_op = 3. T5: Zlowout, Gra, Rin.
- Mem_ready held 0 for 3 cycles in T1: T1 lasts 4 cycles with Read and MDRin high throughout; T2 follows the edge where Mem_ready = 1.
- IR = 0x61000005 (addi R2,R0,5): T4 asserts Cout, Zin, ALU_op = 1, with Rout = 0.
- IR = 0xD8000000 (halt): after T3, state = HALT, Run = 0, all strobes 0 for 10+ cycles.
- Stop pulsed high during T4 and dropped before T5: execution continues to T0. Stop held high through T5: enters HALT at the end of T5.
- Two further cases:
  - IR = 0xF8000000 (opcode 11111): Illegal high for exactly one cycle in T3, then T0.
  - Reset_n dropped mid-T4: all outputs go to 0 asynchronously, before the next clock edge.
